// File: rtl/div_unit_pkg.sv
// Shared definitions for the execute-stage divider: FSM states, latency and
// the HI/LO result layout.
package div_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DBZ  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  localparam int unsigned DIV_CYCLES = 32;

  // HI holds the remainder, LO holds the quotient.
  localparam int unsigned LO_LSB = 0;
  localparam int unsigned LO_MSB = 31;
  localparam int unsigned HI_LSB = 32;
  localparam int unsigned HI_MSB = 63;

endpackage

// File: rtl/div_unit_if.sv
// Handshake/data bundle between the E-stage pipeline (master) and the divider (slave).
interface div_unit_if #(
  parameter int unsigned WIDTH = 32
);

  logic               start_i;
  logic               signed_i;
  logic [WIDTH-1:0]   opa_i;
  logic [WIDTH-1:0]   opb_i;
  logic               annul_i;
  logic               stall_o;
  logic               ready_o;
  logic [2*WIDTH-1:0] result_o;

  modport master (
    output start_i, signed_i, opa_i, opb_i, annul_i,
    input  stall_o, ready_o, result_o
  );

  modport slave (
    input  start_i, signed_i, opa_i, opb_i, annul_i,
    output stall_o, ready_o, result_o
  );

endinterface

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU; one quotient bit per cycle,
// result returned as {remainder, quotient} for the HI/LO write path.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);

  div_state_t         state, state_n;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH:0]   pr;
  logic [WIDTH-1:0]   dvsr;
  logic               q_neg;
  logic               r_neg;
  logic               ready_q;
  logic [2*WIDTH-1:0] result_q;

  logic               load;
  logic               step;
  logic               fin;
  logic               dbz_clr;

  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [2*WIDTH:0]   sh;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH:0]   pr_step;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;

  always_comb begin
    abs_a = (bus.signed_i && bus.opa_i[WIDTH-1]) ? ('0 - bus.opa_i) : bus.opa_i;
    abs_b = (bus.signed_i && bus.opb_i[WIDTH-1]) ? ('0 - bus.opb_i) : bus.opb_i;
  end

  // Restoring step: the shift drops the always-zero top bit of the register.
  always_comb begin
    sh    = pr << 1;
    trial = sh[2*WIDTH:WIDTH] - {1'b0, dvsr};
    if (!trial[WIDTH]) begin
      pr_step = {trial, sh[WIDTH-1:1], 1'b1};
    end else begin
      pr_step = {sh[2*WIDTH:1], 1'b0};
    end
    q_fix = q_neg ? ('0 - pr_step[WIDTH-1:0])       : pr_step[WIDTH-1:0];
    r_fix = r_neg ? ('0 - pr_step[2*WIDTH-1:WIDTH]) : pr_step[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    fin     = 1'b0;
    dbz_clr = 1'b0;
    if (bus.annul_i) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start_i) begin
            if (bus.opb_i == '0) begin
              state_n = DBZ;
            end else begin
              state_n = RUN;
              load    = 1'b1;
            end
          end
        end
        RUN: begin
          step = 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state_n = DONE;
            fin     = 1'b1;
          end
        end
        DBZ: begin
          state_n = DONE;
          dbz_clr = 1'b1;
        end
        DONE: state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      pr       <= '0;
      dvsr     <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      ready_q  <= 1'b0;
      result_q <= '0;
    end else begin
      ready_q <= (state_n == DONE);
      if (load) begin
        pr    <= {{(WIDTH+1){1'b0}}, abs_a};
        dvsr  <= abs_b;
        q_neg <= bus.signed_i & (bus.opa_i[WIDTH-1] ^ bus.opb_i[WIDTH-1]);
        r_neg <= bus.signed_i & bus.opa_i[WIDTH-1];
        cnt   <= '0;
      end else if (step) begin
        pr  <= pr_step;
        cnt <= cnt + 1'b1;
      end
      if (fin) begin
        result_q <= {r_fix, q_fix};
      end else if (dbz_clr) begin
        result_q <= '0;
      end
    end
  end

  assign bus.stall_o  = bus.start_i & ~ready_q & ~bus.annul_i;
  assign bus.ready_o  = ready_q;
  assign bus.result_o = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: table of divides plus annul, back-to-back and
// mid-operation reset sequences.
module tb_div_unit;

  logic clk;
  logic rst;

  div_unit_if #(.WIDTH(32)) bus();

  div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
    int          stalls;
  } vec_t;

  vec_t vecs[10];
  int   tests;
  int   fails;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a drive point with start already set; returns inside the ready cycle.
  task automatic wait_ready(input bit scramble, output int lat, output int stalls,
                            output logic stall_at_rdy);
    lat          = -1;
    stalls       = 0;
    stall_at_rdy = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (scramble && c == 5) begin
        bus.opa_i    = ~bus.opa_i;
        bus.opb_i    = bus.opb_i + 32'd3;
        bus.signed_i = ~bus.signed_i;
      end
      #1;
      if (bus.ready_o === 1'b1) begin
        lat          = c;
        stall_at_rdy = bus.stall_o;
        break;
      end
      if (bus.stall_o === 1'b1) stalls++;
      @(posedge clk);
      #1;
    end
  endtask

  int   lat;
  int   stalls;
  logic sar;
  int   rdy_hits;

  initial begin
    tests = 0;
    fails = 0;
    vecs[0] = '{1'b0, 32'd100,       32'd7,        32'd14,       32'd2,        33, 33};
    vecs[1] = '{1'b1, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 33, 33};
    vecs[2] = '{1'b1, 32'd7,         32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        33, 33};
    vecs[3] = '{1'b1, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 32'd0,        33, 33};
    vecs[4] = '{1'b0, 32'hFFFFFFFF,  32'd1,        32'hFFFFFFFF, 32'd0,        33, 33};
    vecs[5] = '{1'b0, 32'd5,         32'd0,        32'd0,        32'd0,        2,  2};
    vecs[6] = '{1'b0, 32'hFFFFFFFF,  32'h10,       32'h0FFFFFFF, 32'hF,        33, 33};
    vecs[7] = '{1'b0, 32'hFFFFFFF9,  32'd2,        32'h7FFFFFFC, 32'd1,        33, 33};
    vecs[8] = '{1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 33, 33};
    vecs[9] = '{1'b1, 32'h80000000,  32'd0,        32'd0,        32'd0,        2,  2};

    rst          = 1'b1;
    bus.start_i  = 1'b0;
    bus.signed_i = 1'b0;
    bus.opa_i    = '0;
    bus.opb_i    = '0;
    bus.annul_i  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready",  {63'd0, bus.ready_o}, 64'd0);
    chk("reset_result", bus.result_o, 64'd0);
    chk("reset_stall",  {63'd0, bus.stall_o}, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      bus.signed_i = vecs[i].sgn;
      bus.opa_i    = vecs[i].a;
      bus.opb_i    = vecs[i].b;
      bus.start_i  = 1'b1;
      wait_ready(i[0], lat, stalls, sar);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("v%0d_stall_cycles", i), 64'(stalls), 64'(vecs[i].stalls));
      chk($sformatf("v%0d_stall_at_ready", i), {63'd0, sar}, 64'd0);
      chk($sformatf("v%0d_result", i), bus.result_o, {vecs[i].r, vecs[i].q});
      bus.start_i = 1'b0;
      @(posedge clk);
      #1;
    end

    // Annul mid-run: previous result (vector 9) is zero, so seed a nonzero one first.
    bus.signed_i = 1'b0;
    bus.opa_i    = 32'd100;
    bus.opb_i    = 32'd7;
    bus.start_i  = 1'b1;
    wait_ready(1'b0, lat, stalls, sar);
    chk("seed_result", bus.result_o, {32'd2, 32'd14});
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;

    bus.opa_i   = 32'd99;
    bus.opb_i   = 32'd4;
    bus.start_i = 1'b1;
    rdy_hits    = 0;
    for (int c = 0; c < 11; c++) begin
      @(posedge clk);
      #1;
      if (bus.ready_o === 1'b1) rdy_hits++;
    end
    bus.annul_i = 1'b1;
    #1;
    chk("annul_stall", {63'd0, bus.stall_o}, 64'd0);
    @(posedge clk);
    #1;
    bus.annul_i = 1'b0;
    #1;
    if (bus.ready_o === 1'b1) rdy_hits++;
    chk("annul_no_ready", 64'(rdy_hits), 64'd0);
    chk("annul_result_held", bus.result_o, {32'd2, 32'd14});
    bus.opa_i = 32'd1000;
    bus.opb_i = 32'd3;
    wait_ready(1'b0, lat, stalls, sar);
    chk("post_annul_latency", 64'(lat), 64'd33);
    chk("post_annul_result", bus.result_o, {32'd1, 32'd333});

    // start_i stays high across DONE: next instruction's operands.
    bus.opa_i = 32'd50;
    bus.opb_i = 32'd6;
    @(posedge clk);
    #1;
    wait_ready(1'b0, lat, stalls, sar);
    chk("b2b_latency", 64'(lat), 64'd33);
    chk("b2b_stall_cycles", 64'(stalls), 64'd33);
    chk("b2b_result", bus.result_o, {32'd2, 32'd8});
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;

    // Asynchronous reset mid-run.
    bus.opa_i   = 32'd100;
    bus.opb_i   = 32'd7;
    bus.start_i = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    rst         = 1'b1;
    bus.start_i = 1'b0;
    #1;
    chk("rst_mid_ready",  {63'd0, bus.ready_o}, 64'd0);
    chk("rst_mid_result", bus.result_o, 64'd0);
    chk("rst_mid_stall",  {63'd0, bus.stall_o}, 64'd0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    rdy_hits = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (bus.ready_o === 1'b1) rdy_hits++;
    end
    chk("rst_no_ready_after", 64'(rdy_hits), 64'd0);
    chk("rst_result_stays", bus.result_o, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
